// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin share of one single-cycle ALU between two clients,
//             with a tagged one-entry response register and grant counters.
//  Revision : 1.0
// ============================================================================
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_src_a,
   input  logic [WIDTH-1:0] req0_src_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_src_a,
   input  logic [WIDTH-1:0] req1_src_b,
   input  logic [OPW-1:0]   req1_op,
   output logic [WIDTH-1:0] alu_src_a,
   output logic [WIDTH-1:0] alu_src_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_res,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_res,
   output logic [CNTW-1:0]  gnt_cnt0,
   output logic [CNTW-1:0]  gnt_cnt1
);

   localparam logic [CNTW-1:0] c_cnt_max = '1;

   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_res;
   logic             r_last;
   logic [CNTW-1:0]  r_gnt_cnt0;
   logic [CNTW-1:0]  r_gnt_cnt1;

   logic w_can_issue;
   logic w_gnt0;
   logic w_gnt1;
   logic w_acc0;
   logic w_acc1;

   // Under contention the requester that did not win last time is favoured.
   assign w_can_issue = !r_rsp_valid | rsp_ready;
   assign w_gnt0      = req0_valid & (!req1_valid | r_last);
   assign w_gnt1      = req1_valid & (!req0_valid | !r_last);
   assign w_acc0      = w_can_issue & w_gnt0 & !reset;
   assign w_acc1      = w_can_issue & w_gnt1 & !reset;

   assign req0_ready  = w_acc0;
   assign req1_ready  = w_acc1;

   always_comb begin
      alu_src_a = '0;
      alu_src_b = '0;
      alu_op    = '0;
      if (w_acc0) begin
         alu_src_a = req0_src_a;
         alu_src_b = req0_src_b;
         alu_op    = req0_op;
      end else if (w_acc1) begin
         alu_src_a = req1_src_a;
         alu_src_b = req1_src_b;
         alu_op    = req1_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_res   <= '0;
         r_last      <= 1'b1;
         r_gnt_cnt0  <= '0;
         r_gnt_cnt1  <= '0;
      end else begin
         if (w_acc0 | w_acc1) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_acc1;
            r_rsp_res   <= alu_res;
            r_last      <= w_acc1;
         end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
         if (w_acc0 && r_gnt_cnt0 != c_cnt_max)
            r_gnt_cnt0 <= r_gnt_cnt0 + 1'b1;
         if (w_acc1 && r_gnt_cnt1 != c_cnt_max)
            r_gnt_cnt1 <= r_gnt_cnt1 + 1'b1;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_res   = r_rsp_res;
   assign gnt_cnt0  = r_gnt_cnt0;
   assign gnt_cnt1  = r_gnt_cnt1;

endmodule
`default_nettype wire
